ap_ctrl_hs_driver: RTL

AP_CTRL_HS_DRIVER -- requirements
Module: ap_ctrl_hs_driver

---
 rtl/ap_ctrl_hs_pkg.sv | 20 ++
 rtl/ap_ctrl_ts_fifo.sv | 61 ++++++
 rtl/ap_ctrl_hs_driver.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ap_ctrl_hs_pkg.sv
// Shared types and defaults for the ap_ctrl_hs driver; no logic, no latency.
// Latency statistics are enabled by AP_CTRL_HS_DRIVER_LAT_STAT_EN in the top.
package ap_ctrl_hs_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int CNT_W_DEF   = 16;
   localparam int MAX_OUT_DEF = 4;
   localparam int TS_W_DEF    = 32;

   // Pointer width that stays legal for a single-entry FIFO.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ap_ctrl_ts_fifo.sv
// Timestamp FIFO: pop data is the head entry, visible combinationally; push/pop take effect next cycle.
// Same-cycle push and pop are allowed; a push while full is dropped unless a pop frees the slot.
module ap_ctrl_ts_fifo
   import ap_ctrl_hs_pkg::*;
#(
   parameter int DEPTH = MAX_OUT_DEF,
   parameter int WIDTH = TS_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             empty,
   output logic             full
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign pop_dat = mem_q[rd_ptr_q];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_dat;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= nxt(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= nxt(rd_ptr_q);
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/ap_ctrl_hs_driver.sv
// Issues num_trans ap_ctrl_hs starts with up to MAX_OUT in flight; all outputs registered (1 cycle).
// ap_start holds until ap_ready; latency stats only with AP_CTRL_HS_DRIVER_LAT_STAT_EN defined.
module ap_ctrl_hs_driver
   import ap_ctrl_hs_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int MAX_OUT = MAX_OUT_DEF,
   parameter int TS_W    = TS_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             go,
   input  logic [CNT_W-1:0] num_trans,
   output logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   output logic             ap_continue,
   output logic             finish,
   output logic [CNT_W-1:0] issued_cnt,
   output logic [CNT_W-1:0] done_cnt,
   output logic             err,
   output logic [TS_W-1:0]  last_lat,
   output logic [TS_W-1:0]  max_lat
);

   localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [CNT_W-1:0] iss_q, iss_d;
   logic [CNT_W-1:0] dn_q, dn_d;
   logic             start_q, start_d;
   logic             cont_q, cont_d;
   logic             fin_q, fin_d;
   logic             err_q, err_d;

   logic             accept;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] out_d;
   logic             done_hit;

   assign accept      = start_q & ap_ready;
   assign outstanding = iss_q - dn_q;
   assign done_hit    = (state_q == ST_RUN) & ap_done & (outstanding != '0);

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      iss_d   = iss_q;
      dn_d    = dn_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (go) begin
               num_d   = num_trans;
               iss_d   = '0;
               dn_d    = '0;
               err_d   = 1'b0;
               state_d = (num_trans == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (accept) iss_d = iss_q + ONE_C;
            if (ap_done) begin
               if (outstanding != '0) dn_d = dn_q + ONE_C;
               else                   err_d = 1'b1;
            end
            if (done_hit && (dn_d == num_q)) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A pending start never loses its condition: outstanding can only shrink while it waits.
      out_d   = iss_d - dn_d;
      start_d = (state_d == ST_RUN) &&
                ((start_q && !ap_ready) || ((iss_d < num_d) && (out_d < MAX_OUT_C)));
      cont_d  = (state_d == ST_RUN);
      fin_d   = (state_d == ST_DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         num_q   <= '0;
         iss_q   <= '0;
         dn_q    <= '0;
         start_q <= 1'b0;
         cont_q  <= 1'b0;
         fin_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         iss_q   <= iss_d;
         dn_q    <= dn_d;
         start_q <= start_d;
         cont_q  <= cont_d;
         fin_q   <= fin_d;
         err_q   <= err_d;
      end
   end

   assign ap_start    = start_q;
   assign ap_continue = cont_q;
   assign finish      = fin_q;
   assign issued_cnt  = iss_q;
   assign done_cnt    = dn_q;
   assign err         = err_q;

`ifdef AP_CTRL_HS_DRIVER_LAT_STAT_EN
   logic [TS_W-1:0] ts_q;
   logic [TS_W-1:0] last_q;
   logic [TS_W-1:0] max_q;
   logic [TS_W-1:0] ts_head;
   logic            fifo_empty;
   logic            fifo_full;
   logic            clr_stats;

   assign clr_stats = (state_q != ST_RUN) & go;

   ap_ctrl_ts_fifo #(
      .DEPTH (MAX_OUT),
      .WIDTH (TS_W)
   ) u_ts_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (accept & ~fifo_full),
      .push_dat (ts_q),
      .pop      (done_hit & ~fifo_empty),
      .pop_dat  (ts_head),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   // max_lat trails last_lat by one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         ts_q   <= '0;
         last_q <= '0;
         max_q  <= '0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
         if (clr_stats) begin
            last_q <= '0;
            max_q  <= '0;
         end else begin
            if (done_hit)         last_q <= ts_q - ts_head;
            if (last_q > max_q)   max_q  <= last_q;
         end
      end
   end

   assign last_lat = last_q;
   assign max_lat  = max_q;
`else
   assign last_lat = '0;
   assign max_lat  = '0;
`endif

endmodule
